// File: rtl/frame_pipe_sequencer_if.sv
// Handshake/bus bundle between frame_pipe_sequencer (master) and its surrounding
// crop filter, normalizer and upstream frame source (slave).
interface frame_pipe_sequencer_if #(
    parameter int CNT_WIDTH = 16
) ();
    logic                 sof_pulse;
    logic                 seq_ap_idle;
    logic                 cf_ap_start;
    logic                 cf_ap_ready;
    logic                 cf_ap_done;
    logic [7:0]           cf_max_value;
    logic                 nr_ap_start;
    logic                 nr_ap_ready;
    logic                 nr_ap_done;
    logic [7:0]           norm_denominator;
    logic                 busy;
    logic                 frame_done;
    logic [CNT_WIDTH-1:0] frames_done;
    logic [CNT_WIDTH-1:0] frames_dropped;
    logic                 timeout_err;

    modport master (
        input  sof_pulse, seq_ap_idle, cf_ap_ready, cf_ap_done, cf_max_value,
               nr_ap_ready, nr_ap_done,
        output cf_ap_start, nr_ap_start, norm_denominator, busy, frame_done,
               frames_done, frames_dropped, timeout_err
    );

    modport slave (
        output sof_pulse, seq_ap_idle, cf_ap_ready, cf_ap_done, cf_max_value,
               nr_ap_ready, nr_ap_done,
        input  cf_ap_start, nr_ap_start, norm_denominator, busy, frame_done,
               frames_done, frames_dropped, timeout_err
    );
endinterface

// File: rtl/frame_pipe_sequencer.sv
// Per-frame crop -> normalize controller with frame/drop counters.
// Optional per-phase watchdog: define FRAME_PIPE_SEQ_TIMEOUT_EN.
module frame_pipe_sequencer #(
    parameter int CNT_WIDTH      = 16,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic                  clk,
    input  logic                  s_axis_resetn,
    frame_pipe_sequencer_if.master bus
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LAUNCH = 3'd1,
        ST_CROP   = 3'd2,
        ST_NORM   = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    state_t               r_state;
    state_t               w_next_state;
    logic                 w_accept;
    logic                 w_drop;
    logic                 w_wd_expire;
    logic                 r_cf_start;
    logic                 r_nr_start;
    logic                 r_busy;
    logic                 r_frame_done;
    logic [7:0]           r_denom;
    logic [CNT_WIDTH-1:0] r_frames_done;
    logic [CNT_WIDTH-1:0] r_frames_dropped;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("frame_pipe_sequencer: TIMEOUT_CYCLES must be positive");
    end

    // A zero maximum would make the normalizer divide by zero; clamp to 1.
    function automatic logic [7:0] f_clamp_denom(input logic [7:0] v);
        f_clamp_denom = (v == 8'd0) ? 8'd1 : v;
    endfunction

`ifdef FRAME_PIPE_SEQ_TIMEOUT_EN
    localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [WD_W-1:0] r_wd_cnt;
    logic            r_timeout_err;
    logic            w_phase_done;

    // Watchdog counter: counts cycles spent in CROP/NORM, cleared on any state change.
    always_ff @(posedge clk or negedge s_axis_resetn) begin
        if (!s_axis_resetn) begin
            r_wd_cnt <= '0;
        end else if (w_next_state != r_state) begin
            r_wd_cnt <= '0;
        end else if ((r_state == ST_CROP) || (r_state == ST_NORM)) begin
            r_wd_cnt <= r_wd_cnt + WD_W'(1);
        end else begin
            r_wd_cnt <= '0;
        end
    end

    // Expiry decode; a completion arriving in the same cycle wins over the watchdog.
    always_comb begin
        w_wd_expire  = 1'b0;
        w_phase_done = 1'b0;
        if ((r_state == ST_CROP) || (r_state == ST_NORM)) begin
            w_wd_expire  = (r_wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));
            w_phase_done = (r_state == ST_CROP) ? bus.cf_ap_done : bus.nr_ap_done;
        end else begin
            w_wd_expire  = 1'b0;
            w_phase_done = 1'b0;
        end
    end

    // Sticky timeout flag, cleared only by reset.
    always_ff @(posedge clk or negedge s_axis_resetn) begin
        if (!s_axis_resetn) begin
            r_timeout_err <= 1'b0;
        end else if (w_wd_expire && !w_phase_done) begin
            r_timeout_err <= 1'b1;
        end else begin
            r_timeout_err <= r_timeout_err;
        end
    end

    assign bus.timeout_err = r_timeout_err;
`else
    assign w_wd_expire     = 1'b0;
    assign bus.timeout_err = 1'b0;
`endif

    // Next-state decode, frame acceptance and drop detection.
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_drop       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.sof_pulse && bus.seq_ap_idle && bus.cf_ap_ready && bus.nr_ap_ready) begin
                    w_accept     = 1'b1;
                    w_next_state = ST_LAUNCH;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_LAUNCH: w_next_state = ST_CROP;
            ST_CROP: begin
                if (bus.cf_ap_done) begin
                    w_next_state = ST_NORM;
                end else if (w_wd_expire) begin
                    w_next_state = ST_IDLE;
                end else begin
                    w_next_state = ST_CROP;
                end
            end
            ST_NORM: begin
                if (bus.nr_ap_done) begin
                    w_next_state = ST_DONE;
                end else if (w_wd_expire) begin
                    w_next_state = ST_IDLE;
                end else begin
                    w_next_state = ST_NORM;
                end
            end
            ST_DONE: w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
        w_drop = bus.sof_pulse && !w_accept;
    end

    // State register plus registered outputs derived from the upcoming state.
    always_ff @(posedge clk or negedge s_axis_resetn) begin
        if (!s_axis_resetn) begin
            r_state          <= ST_IDLE;
            r_cf_start       <= 1'b0;
            r_nr_start       <= 1'b0;
            r_busy           <= 1'b0;
            r_frame_done     <= 1'b0;
            r_denom          <= 8'd1;
            r_frames_done    <= '0;
            r_frames_dropped <= '0;
        end else begin
            r_state      <= w_next_state;
            r_cf_start   <= (w_next_state == ST_LAUNCH);
            r_nr_start   <= (w_next_state == ST_LAUNCH);
            r_busy       <= (w_next_state != ST_IDLE);
            r_frame_done <= (w_next_state == ST_DONE);

            if ((r_state == ST_CROP) && bus.cf_ap_done) begin
                r_denom <= f_clamp_denom(bus.cf_max_value);
            end else begin
                r_denom <= r_denom;
            end

            if (r_state == ST_DONE) begin
                r_frames_done <= r_frames_done + CNT_WIDTH'(1);
            end else begin
                r_frames_done <= r_frames_done;
            end

            // Drop counter saturates so a flood of rejected frames stays visible.
            if (w_drop && (r_frames_dropped != {CNT_WIDTH{1'b1}})) begin
                r_frames_dropped <= r_frames_dropped + CNT_WIDTH'(1);
            end else begin
                r_frames_dropped <= r_frames_dropped;
            end
        end
    end

    assign bus.cf_ap_start      = r_cf_start;
    assign bus.nr_ap_start      = r_nr_start;
    assign bus.busy             = r_busy;
    assign bus.frame_done       = r_frame_done;
    assign bus.norm_denominator = r_denom;
    assign bus.frames_done      = r_frames_done;
    assign bus.frames_dropped   = r_frames_dropped;

endmodule

// File: tb/tb_frame_pipe_sequencer.sv
// Self-checking bench: timing-rule model compared every cycle, plus directed literal checks.
module tb_frame_pipe_sequencer;

    localparam int CW   = 16;
    localparam int MAXC = 65535;
`ifdef FRAME_PIPE_SEQ_TIMEOUT_EN
    localparam int TO    = 100;
    localparam bit TO_EN = 1'b1;
`else
    localparam int TO    = 1_000_000;
    localparam bit TO_EN = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    int   n_cf_starts;
    int   n_nr_starts;

    frame_pipe_sequencer_if #(.CNT_WIDTH(CW)) u_if ();

    frame_pipe_sequencer #(.CNT_WIDTH(CW), .TIMEOUT_CYCLES(TO)) u_dut (
        .clk           (clk),
        .s_axis_resetn (rst_n),
        .bus           (u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: frame milestones recorded as cycle numbers; outputs follow from timing rules.
    int m_cyc, m_acc, m_cfd, m_nrd, m_done, m_drop, m_denom;
    bit m_to, m_idle_now;

    initial begin : model
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_cyc = 0; m_acc = -1; m_cfd = -1; m_nrd = -1;
                m_done = 0; m_drop = 0; m_denom = 1; m_to = 1'b0;
            end else begin
                if (m_acc >= 0 && m_nrd >= 0 && m_cyc >= m_nrd + 2) begin
                    m_acc = -1; m_cfd = -1; m_nrd = -1;
                end
                m_idle_now = (m_acc < 0);
                if (m_nrd >= 0 && m_cyc == m_nrd + 1) m_done = (m_done + 1) % (MAXC + 1);
                if (m_acc >= 0 && m_cyc >= m_acc + 2) begin
                    if (m_cfd < 0) begin
                        if (u_if.cf_ap_done) begin
                            m_cfd   = m_cyc;
                            m_denom = (u_if.cf_max_value == 8'd0) ? 1 : int'(u_if.cf_max_value);
                        end else if (TO_EN && (m_cyc - (m_acc + 2) == TO - 1)) begin
                            m_to = 1'b1; m_acc = -1; m_cfd = -1; m_nrd = -1;
                        end
                    end else if (m_nrd < 0 && m_cyc > m_cfd) begin
                        if (u_if.nr_ap_done) begin
                            m_nrd = m_cyc;
                        end else if (TO_EN && (m_cyc - (m_cfd + 1) == TO - 1)) begin
                            m_to = 1'b1; m_acc = -1; m_cfd = -1; m_nrd = -1;
                        end
                    end
                end
                if (u_if.sof_pulse) begin
                    if (m_idle_now && u_if.seq_ap_idle && u_if.cf_ap_ready && u_if.nr_ap_ready)
                        m_acc = m_cyc;
                    else if (m_drop < MAXC)
                        m_drop = m_drop + 1;
                end
                m_cyc = m_cyc + 1;
            end
        end
    end

    // Compare process: every cycle, mid-cycle, against the model.
    initial begin : compare
        bit e_start, e_busy, e_fd;
        forever begin
            @(negedge clk);
            #1;
            e_start = (m_acc >= 0) && (m_cyc == m_acc + 1);
            e_busy  = (m_acc >= 0) && (m_cyc > m_acc) && !(m_nrd >= 0 && m_cyc >= m_nrd + 2);
            e_fd    = (m_nrd >= 0) && (m_cyc == m_nrd + 1);
            chk("cf_ap_start", 32'(u_if.cf_ap_start), 32'(e_start));
            chk("nr_ap_start", 32'(u_if.nr_ap_start), 32'(e_start));
            chk("busy", 32'(u_if.busy), 32'(e_busy));
            chk("frame_done", 32'(u_if.frame_done), 32'(e_fd));
            chk("frames_done", 32'(u_if.frames_done), 32'(m_done));
            chk("frames_dropped", 32'(u_if.frames_dropped), 32'(m_drop));
            chk("norm_denominator", 32'(u_if.norm_denominator), 32'(m_denom));
            chk("timeout_err", 32'(u_if.timeout_err), 32'(m_to));
            if (u_if.cf_ap_start === 1'b1) n_cf_starts++;
            if (u_if.nr_ap_start === 1'b1) n_nr_starts++;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_sof();
        u_if.sof_pulse = 1'b1; tick(1); u_if.sof_pulse = 1'b0;
    endtask

    task automatic pulse_cf(input logic [7:0] maxv);
        u_if.cf_ap_done = 1'b1; u_if.cf_max_value = maxv; tick(1);
        u_if.cf_ap_done = 1'b0; u_if.cf_max_value = 8'd0;
    endtask

    task automatic pulse_nr();
        u_if.nr_ap_done = 1'b1; tick(1); u_if.nr_ap_done = 1'b0;
    endtask

    task automatic wait_frame_done(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (u_if.frame_done === 1'b1) begin
                seen = 1'b1;
                break;
            end
            tick(1);
        end
        chk(name, 32'(seen), 32'd1);
    endtask

    initial begin : watchdog
        #2_000_000;
        failures++;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "tb timeout");
    end

    initial begin : stim
        checks = 0; failures = 0; n_cf_starts = 0; n_nr_starts = 0;
        rst_n = 1'b0;
        u_if.sof_pulse = 1'b0; u_if.seq_ap_idle = 1'b1;
        u_if.cf_ap_ready = 1'b1; u_if.cf_ap_done = 1'b0; u_if.cf_max_value = 8'd0;
        u_if.nr_ap_ready = 1'b1; u_if.nr_ap_done = 1'b0;
        tick(3);
        chk("rst_busy", 32'(u_if.busy), 32'd0);
        chk("rst_cf_start", 32'(u_if.cf_ap_start), 32'd0);
        chk("rst_nr_start", 32'(u_if.nr_ap_start), 32'd0);
        chk("rst_frame_done", 32'(u_if.frame_done), 32'd0);
        chk("rst_denom", 32'(u_if.norm_denominator), 32'd1);
        chk("rst_frames_done", 32'(u_if.frames_done), 32'd0);
        chk("rst_dropped", 32'(u_if.frames_dropped), 32'd0);
        chk("rst_timeout", 32'(u_if.timeout_err), 32'd0);
        rst_n = 1'b1;
        tick(2);

        // Normal frame with maximum 200
        pulse_sof(); tick(4); pulse_cf(8'd200); tick(3); pulse_nr();
        wait_frame_done("normal_frame_done");
        tick(2);
        chk("normal_frames_done", 32'(u_if.frames_done), 32'd1);
        chk("normal_denom", 32'(u_if.norm_denominator), 32'd200);
        chk("normal_cf_starts", 32'(n_cf_starts), 32'd1);
        chk("normal_nr_starts", 32'(n_nr_starts), 32'd1);

        // Zero maximum clamps to 1
        pulse_sof(); tick(3); pulse_cf(8'd0); tick(2); pulse_nr();
        wait_frame_done("zero_frame_done");
        tick(2);
        chk("zero_denom", 32'(u_if.norm_denominator), 32'd1);
        chk("zero_frames_done", 32'(u_if.frames_done), 32'd2);

        // Drop while downstream busy, then a drop during NORM
        u_if.seq_ap_idle = 1'b0; pulse_sof(); tick(2); u_if.seq_ap_idle = 1'b1;
        chk("drop1_count", 32'(u_if.frames_dropped), 32'd1);
        chk("drop1_no_start", 32'(n_cf_starts), 32'd2);
        pulse_sof(); tick(3); pulse_cf(8'd77); tick(2); pulse_sof(); tick(2); pulse_nr();
        wait_frame_done("drop2_frame_done");
        tick(2);
        chk("drop2_count", 32'(u_if.frames_dropped), 32'd2);
        chk("drop2_frames_done", 32'(u_if.frames_done), 32'd3);
        chk("drop2_denom", 32'(u_if.norm_denominator), 32'd77);

        // sof_pulse in the DONE cycle: both counters bump together
        pulse_sof(); tick(3); pulse_cf(8'd9); tick(1);
        u_if.nr_ap_done = 1'b1; tick(1);
        u_if.nr_ap_done = 1'b0; u_if.sof_pulse = 1'b1; tick(1);
        u_if.sof_pulse = 1'b0;
        tick(1);
        chk("sim_frames_done", 32'(u_if.frames_done), 32'd4);
        chk("sim_dropped", 32'(u_if.frames_dropped), 32'd3);

        // Reset during NORM
        tick(2);
        pulse_sof(); tick(3); pulse_cf(8'd50); tick(2);
        rst_n = 1'b0; tick(1);
        chk("midrst_busy", 32'(u_if.busy), 32'd0);
        chk("midrst_frames_done", 32'(u_if.frames_done), 32'd0);
        chk("midrst_dropped", 32'(u_if.frames_dropped), 32'd0);
        chk("midrst_denom", 32'(u_if.norm_denominator), 32'd1);
        rst_n = 1'b1; tick(2);
        pulse_sof(); tick(3); pulse_cf(8'd33); tick(1); pulse_nr();
        wait_frame_done("recover_frame_done");
        tick(2);
        chk("recover_frames_done", 32'(u_if.frames_done), 32'd1);

`ifdef FRAME_PIPE_SEQ_TIMEOUT_EN
        // Watchdog: crop never finishes
        begin
            int busy_cycles;
            busy_cycles = 0;
            pulse_sof();
            for (int i = 0; i < 150; i++) begin
                if (u_if.busy === 1'b1) busy_cycles++;
                tick(1);
            end
            chk("wd_busy_cycles", 32'(busy_cycles), 32'd101);
            chk("wd_timeout_err", 32'(u_if.timeout_err), 32'd1);
            chk("wd_frames_done", 32'(u_if.frames_done), 32'd1);
        end
`endif

        tick(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/frame_pipe_sequencer.md
# frame_pipe_sequencer

Per-frame controller for the crop → normalize → downstream chain. On each start-of-frame it launches the crop filter and the normalization reader together. When cropping finishes it hands the crop filter's maximum pixel value to the normalizer as its denominator. It then waits for the normalizer to drain a full image before accepting the next frame, and counts completed and dropped frames.

## Interface
Parameters:
- `CNT_WIDTH`, 16: width of the frame counters.
- `TIMEOUT_CYCLES`, 1_000_000: watchdog limit per CROP/NORM phase; used only when the watchdog is compiled in.

Ports (name, direction, width, meaning):
- `clk` in 1: the single clock.
- `s_axis_resetn` in 1: asynchronous, active-low reset.
- `sof_pulse` in 1: one-cycle start-of-frame from upstream.
- `seq_ap_idle` in 1: downstream sequencer is idle.
- `cf_ap_start` out 1: crop filter start pulse.
- `cf_ap_ready` in 1: crop filter can accept a start.
- `cf_ap_done` in 1: crop filter finished the frame.
- `cf_max_value` in 8: frame maximum; valid in the `cf_ap_done` cycle.
- `nr_ap_start` out 1: normalizer start pulse.
- `nr_ap_ready` in 1: normalizer can accept a start.
- `nr_ap_done` in 1: normalizer has emitted a full cropped image.
- `norm_denominator` out 8: registered divisor for the normalizer.
- `busy` out 1: high in any state other than IDLE.
- `frame_done` out 1: one-cycle pulse per completed frame.
- `frames_done` out `CNT_WIDTH`: completed frames; wraps.
- `frames_dropped` out `CNT_WIDTH`: rejected `sof_pulse` count; saturates at all-ones.
- `timeout_err` out 1: sticky watchdog flag.

## Operation
States are IDLE, LAUNCH, CROP, NORM and DONE.
- **IDLE:** if `sof_pulse && seq_ap_idle && cf_ap_ready && nr_ap_ready`, go to LAUNCH. If `sof_pulse` arrives with any of those low, increment `frames_dropped` and stay in IDLE.
- **LAUNCH:** assert `cf_ap_start` and `nr_ap_start` for exactly this one cycle, then go to CROP.
- **CROP:** wait for `cf_ap_done`. On that cycle, register `norm_denominator <= (cf_max_value==0) ? 8'd1 : cf_max_value`, then go to NORM. Any `nr_ap_done` seen in CROP is ignored.
- **NORM:** wait for `nr_ap_done`, then go to DONE. Any `cf_ap_done` seen in NORM is ignored.
- **DONE:** pulse `frame_done` for one cycle, increment `frames_done` (wrapping from all-ones to 0), then go to IDLE.
- **`sof_pulse` outside IDLE** (any of LAUNCH/CROP/NORM/DONE): increment `frames_dropped` (saturating); the state is unchanged.
- **Both counters bumping in DONE:** when `sof_pulse` arrives in DONE, `frames_done` and `frames_dropped` both increment in the same cycle.
- **Reset values:** IDLE; `cf_ap_start`=0; `nr_ap_start`=0; `busy`=0; `frame_done`=0; `frames_done`=0; `frames_dropped`=0; `norm_denominator`=8'd1; `timeout_err`=0.
- **Reset mid-frame:** deasserting `s_axis_resetn` at any point returns the block to IDLE immediately. No start pulse is emitted and counters clear.

## Timing
- `sof_pulse` accepted at cycle T: `cf_ap_start`/`nr_ap_start` high at T+1; state CROP at T+2.
- `cf_ap_done` at cycle C: `norm_denominator` is valid from C+1. This matches the normalizer's ready-to-normalize flag, which it registers on `cf_ap_done`.
- `nr_ap_done` at cycle N: `frame_done` high at N+1; IDLE at N+2. The earliest next accepted `sof_pulse` is at N+2.
- Minimum frame period: 4 cycles plus crop and normalize latency.
- All outputs are registered; no combinational input-to-output paths.

## Configuration
- **`FRAME_PIPE_SEQ_TIMEOUT_EN` defined:**
  - A cycle counter runs in CROP and in NORM and is cleared on every state change.
  - When it reaches `TIMEOUT_CYCLES`, the state goes to IDLE without asserting `frame_done` or incrementing `frames_done`.
  - `timeout_err` is set and held until reset.
- **Not defined:** no counter is built, `timeout_err` is tied to 0, and CROP/NORM wait indefinitely.

## Test plan
- **Normal frame:** reset, all readies high, `sof_pulse`, `cf_ap_done` with `cf_max_value`=200 five cycles later, then `nr_ap_done` → single start pulses on both start outputs, `norm_denominator`=200, one `frame_done`, `frames_done`=1.
- **Zero maximum:** `cf_max_value`=0 at `cf_ap_done` → `norm_denominator`=1.
- **Drops:** `sof_pulse` with `seq_ap_idle`=0 → no start pulses, `frames_dropped`=1. A second `sof_pulse` during NORM → `frames_dropped`=2 and the frame still completes.
- **Simultaneous drop and completion:** `sof_pulse` in the DONE cycle → `frames_done` and `frames_dropped` both increment.
- **Reset mid-frame:** `s_axis_resetn` low during NORM → IDLE, `busy`=0, counters 0, `norm_denominator`=1.
- **Watchdog:** with `FRAME_PIPE_SEQ_TIMEOUT_EN` and `TIMEOUT_CYCLES`=100, `cf_ap_done` withheld → IDLE after 100 cycles in CROP, `timeout_err`=1, `frames_done` unchanged.
